// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: state encodings, master indices and burst-bound default for the dm arbiter.
package dm_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam int LOCK_MAX_DEF = 4;
endpackage

// File: rtl/dm_arbiter_pick.sv
// dm_arbiter_pick: two-way request picker; on a tie the pointer's master wins.
module dm_arbiter_pick
  import dm_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_idx,
  output logic       o_valid
);
  assign o_valid = |i_req;
  assign o_idx   = &i_req ? i_ptr : i_req[M1];
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter for the single-port data memory with bounded locked bursts.
// DM_ARB_RR_EN selects round-robin tie breaking; otherwise M0 wins ties.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              M0Req,
  input  logic              M0We,
  input  logic [ADDR_W-1:0] M0Addr,
  input  logic [DATA_W-1:0] M0Wdata,
  input  logic              M0Lock,
  output logic              M0Gnt,
  output logic              M0Rvalid,
  output logic [DATA_W-1:0] M0Rdata,
  input  logic              M1Req,
  input  logic              M1We,
  input  logic [ADDR_W-1:0] M1Addr,
  input  logic [DATA_W-1:0] M1Wdata,
  input  logic              M1Lock,
  output logic              M1Gnt,
  output logic              M1Rvalid,
  output logic [DATA_W-1:0] M1Rdata,
  output logic [ADDR_W-1:0] DmAddr,
  output logic [DATA_W-1:0] DmData,
  output logic              DmMemWrite,
  output logic              DmMemRead,
  input  logic [DATA_W-1:0] DmOut
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX - 1);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0] r_rvalid, w_req;
  logic [DATA_W-1:0] r_rdata0, r_rdata1, w_wdata;
  logic [ADDR_W-1:0] w_addr;
  logic w_busy, w_cur, w_act, w_we, w_own_req, w_own_lock, w_oth_req, w_stay;
  logic w_ptr, w_idx, w_valid;
  assign w_busy     = r_state != ST_IDLE;
  assign w_cur      = r_state == ST_BUSY1;
  assign w_act      = w_busy & ~Reset;
  assign w_we       = w_cur ? M1We : M0We;
  assign w_addr     = w_cur ? M1Addr : M0Addr;
  assign w_wdata    = w_cur ? M1Wdata : M0Wdata;
  assign w_own_req  = w_cur ? M1Req : M0Req;
  assign w_own_lock = w_cur ? M1Lock : M0Lock;
  assign w_oth_req  = w_cur ? M0Req : M1Req;
  // The granted master's own Req is stale at its closing edge unless it locked the next access.
  assign w_stay = w_busy & w_own_lock & w_own_req & ~(w_oth_req & (r_cnt == CNT_MAX));
  assign w_req  = !w_busy ? {M1Req, M0Req} : w_cur ? {1'b0, M0Req} : {M1Req, 1'b0};
  dm_arbiter_pick u_pick (
    .i_req  (w_req),
    .i_ptr  (w_ptr),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );
`ifdef DM_ARB_RR_EN
  logic r_ptr;
  // Pointer flips each time a busy period drains back to idle.
  always_ff @(posedge Clk)
    r_ptr <= Reset ? 1'b0 : r_ptr ^ (w_busy & (w_next == ST_IDLE));
  assign w_ptr = r_ptr;
`else
  assign w_ptr = M0;
`endif
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    w_next     = w_stay ? r_state : !w_valid ? ST_IDLE : (w_idx == M1) ? ST_BUSY1 : ST_BUSY0;
    w_cnt_next = !w_stay ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rvalid <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_rvalid <= {w_act & w_cur & ~w_we, w_act & ~w_cur & ~w_we};
      if (w_act & ~w_we & ~w_cur) r_rdata0 <= DmOut;
      if (w_act & ~w_we & w_cur) r_rdata1 <= DmOut;
    end
  end
  assign M0Gnt      = w_act & ~w_cur;
  assign M1Gnt      = w_act & w_cur;
  assign M0Rvalid   = r_rvalid[0];
  assign M1Rvalid   = r_rvalid[1];
  assign M0Rdata    = r_rdata0;
  assign M1Rdata    = r_rdata1;
  assign DmAddr     = w_act ? w_addr : '0;
  assign DmData     = w_act ? w_wdata : '0;
  assign DmMemWrite = w_act & w_we;
  assign DmMemRead  = w_act & ~w_we;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: vector table, directed burst/tie/reset sequences and randomized traffic vs a reference model.
module tb_dm_arbiter;
  localparam int LOCK_MAX = 4;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [1:0] req = '0, we = '0, lock = '0;
  logic [9:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0] gnt, rvalid;
  logic [31:0] rdata [2];
  logic [9:0] DmAddr;
  logic [31:0] DmData, DmOut;
  logic DmMemWrite, DmMemRead;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int npass = 0, ntot = 0;
  typedef struct {
    logic        m;
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [7];

  always #5 Clk = ~Clk;

  dm_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .M0Req(req[0]), .M0We(we[0]), .M0Addr(addr[0]), .M0Wdata(wdata[0]), .M0Lock(lock[0]),
    .M0Gnt(gnt[0]), .M0Rvalid(rvalid[0]), .M0Rdata(rdata[0]),
    .M1Req(req[1]), .M1We(we[1]), .M1Addr(addr[1]), .M1Wdata(wdata[1]), .M1Lock(lock[1]),
    .M1Gnt(gnt[1]), .M1Rvalid(rvalid[1]), .M1Rdata(rdata[1]),
    .DmAddr(DmAddr), .DmData(DmData), .DmMemWrite(DmMemWrite), .DmMemRead(DmMemRead),
    .DmOut(DmOut)
  );

  assign DmOut = mem[DmAddr];
  always @(posedge Clk) if (DmMemWrite) mem[DmAddr] <= DmData;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic smp;
    @(negedge Clk);
  endtask

  task automatic set_acc(input int m, input logic r, input logic w, input logic [9:0] a,
                         input logic [31:0] d, input logic l);
    req[m] = r;
    we[m] = w;
    addr[m] = a;
    wdata[m] = d;
    lock[m] = l;
  endtask

  task automatic do_reset;
    tick;
    Reset = 1'b1;
    req = '0;
    lock = '0;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  task automatic single(input vec_t v);
    tick;
    set_acc(int'(v.m), 1'b1, v.w, v.a, v.d, 1'b0);
    smp;
    chk("vec_idle_gnt", 32'(gnt), 32'd0);
    tick;
    smp;
    chk("vec_gnt", 32'(gnt), v.m ? 32'd2 : 32'd1);
    chk("vec_dm_addr", 32'(DmAddr), 32'(v.a));
    chk("vec_dm_write", 32'(DmMemWrite), 32'(v.w));
    chk("vec_dm_read", 32'(DmMemRead), 32'(!v.w));
    if (v.w) chk("vec_dm_data", DmData, v.d);
    tick;
    req[v.m] = 1'b0;
    smp;
    chk("vec_rvalid", 32'(rvalid), v.w ? 32'd0 : (v.m ? 32'd2 : 32'd1));
    if (!v.w) chk("vec_rdata", rdata[v.m], v.rd);
    tick;
    smp;
    chk("vec_rvalid_pulse", 32'(rvalid), 32'd0);
    if (v.w) chk("vec_mem", mem[v.a], v.d);
  endtask

  task automatic burst(input bit with_m1);
    int k;
    bit m1_done;
    logic [1:0] g;
    logic [1:0] seq [$];
    logic [1:0] exp_seq [$];
    do_reset;
    k = 0;
    m1_done = !with_m1;
    tick;
    set_acc(0, 1'b1, 1'b1, 10'h20, 32'hA000_0000, 1'b1);
    if (with_m1) set_acc(1, 1'b1, 1'b1, 10'h30, 32'hBEEF_0001, 1'b0);
    for (int c = 0; c < 40 && !(k == 8 && m1_done); c++) begin
      smp;
      g = gnt;
      if (g != 2'b00 || seq.size() > 0) seq.push_back(g);
      tick;
      if (g[0]) begin
        k++;
        if (k < 8) set_acc(0, 1'b1, 1'b1, 10'h20 + 10'(k), 32'hA000_0000 + k, k < 7);
        else req[0] = 1'b0;
      end
      if (g[1]) begin
        m1_done = 1'b1;
        req[1] = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (with_m1 && i == 4) exp_seq.push_back(2'b10);
      exp_seq.push_back(2'b01);
    end
    chk(with_m1 ? "burst_m1_len" : "burst_solo_len", seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++)
      chk(with_m1 ? "burst_m1_order" : "burst_solo_order",
          32'(i < seq.size() ? seq[i] : 2'bxx), 32'(exp_seq[i]));
    for (int i = 0; i < 8; i++) chk("burst_mem", mem[10'h20 + 10'(i)], 32'hA000_0000 + i);
    if (with_m1) chk("burst_m1_mem", mem[10'h30], 32'hBEEF_0001);
  endtask

  task automatic new_acc(input int m);
    set_acc(m, 1'b1, 1'($urandom), 10'($urandom_range(15)), $urandom, $urandom_range(3) != 0);
  endtask

  initial begin
    int cur, run, nc;
    bit ptr;
    logic [1:0] exp_g, exp_rv, g_last;
    logic [31:0] exp_rd [2];
    logic f;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0;
      wdata[m] = '0;
    end
    tbl[0] = '{1'b0, 1'b1, 10'h004, 32'h1234_5678, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 10'h004, 32'h0, 32'h1234_5678};
    tbl[2] = '{1'b1, 1'b1, 10'h3FF, 32'hCAFE_F00D, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 10'h3FF, 32'h0, 32'hCAFE_F00D};
    tbl[4] = '{1'b0, 1'b0, 10'h3FF, 32'h0, 32'hCAFE_F00D};
    tbl[5] = '{1'b1, 1'b0, 10'h004, 32'h0, 32'h1234_5678};
    tbl[6] = '{1'b0, 1'b0, 10'h000, 32'h0, 32'h0};

    do_reset;
    smp;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    chk("rst_rdata1", rdata[1], 32'd0);
    chk("rst_dm_ctl", 32'({DmMemWrite, DmMemRead}), 32'd0);
    chk("rst_dm_addr", 32'(DmAddr), 32'd0);

    for (int i = 0; i < 7; i++) single(tbl[i]);

    do_reset;
    smp;
    chk("rst_rdata_clr", rdata[1], 32'd0);
    for (int r = 0; r < 2; r++) begin
`ifdef DM_ARB_RR_EN
      f = (r == 1);
`else
      f = 1'b0;
`endif
      tick;
      set_acc(0, 1'b1, 1'b1, 10'h10, 32'h1111_0000 + r, 1'b0);
      set_acc(1, 1'b1, 1'b1, 10'h11, 32'h2222_0000 + r, 1'b0);
      smp;
      chk("tie_idle", 32'(gnt), 32'd0);
      tick;
      smp;
      chk("tie_first", 32'(gnt), f ? 32'd2 : 32'd1);
      tick;
      req[f] = 1'b0;
      smp;
      chk("tie_second", 32'(gnt), f ? 32'd1 : 32'd2);
      tick;
      req[!f] = 1'b0;
      smp;
      chk("tie_done", 32'(gnt), 32'd0);
    end

    burst(1'b1);
    burst(1'b0);

    for (int w = 0; w < 2; w++) begin
      do_reset;
      tick;
      set_acc(1, 1'b1, 1'(w), 10'h55, 32'hDEAD_BEEF, 1'b0);
      smp;
      tick;
      Reset = 1'b1;
      smp;
      chk("rstmid_write_off", 32'(DmMemWrite), 32'd0);
      tick;
      Reset = 1'b0;
      req[1] = 1'b0;
      smp;
      chk("rstmid_idle", 32'(gnt), 32'd0);
      chk("rstmid_rvalid", 32'(rvalid), 32'd0);
      chk("rstmid_write_after", 32'(DmMemWrite), 32'd0);
      tick;
      smp;
      chk("rstmid_rvalid_late", 32'(rvalid), 32'd0);
      chk("rstmid_mem", mem[10'h55], 32'd0);
    end

    do_reset;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    cur = -1;
    run = 0;
    ptr = 1'b0;
    exp_rv = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    g_last = '0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      for (int m = 0; m < 2; m++) begin
        if (req[m] && g_last[m]) begin
          if (lock[m] || $urandom_range(2) == 0) new_acc(m);
          else req[m] = 1'b0;
        end else if (!req[m] && $urandom_range(3) == 0) new_acc(m);
      end
      smp;
      exp_g = (cur < 0) ? 2'b00 : (cur == 0) ? 2'b01 : 2'b10;
      chk("rnd_gnt", 32'(gnt), 32'(exp_g));
      chk("rnd_rvalid", 32'(rvalid), 32'(exp_rv));
      chk("rnd_rdata0", rdata[0], exp_rd[0]);
      chk("rnd_rdata1", rdata[1], exp_rd[1]);
      if (cur >= 0) begin
        chk("rnd_dm_addr", 32'(DmAddr), 32'(addr[cur]));
        chk("rnd_dm_write", 32'(DmMemWrite), 32'(we[cur]));
      end else chk("rnd_dm_quiet", 32'({DmMemWrite, DmMemRead}), 32'd0);
      g_last = exp_g;
      exp_rv = '0;
      if (cur >= 0) begin
        if (!we[cur]) begin
          exp_rv[cur] = 1'b1;
          exp_rd[cur] = ref_mem[addr[cur]];
        end else ref_mem[addr[cur]] = wdata[cur];
      end
      if (cur < 0) nc = (req == 2'b11) ? int'(ptr) : req[0] ? 0 : req[1] ? 1 : -1;
      else if (req[cur] && lock[cur] && !(req[1-cur] && run >= LOCK_MAX)) nc = cur;
      else nc = req[1-cur] ? 1 - cur : -1;
`ifdef DM_ARB_RR_EN
      if (cur >= 0 && nc < 0) ptr = !ptr;
`endif
      run = (nc < 0) ? 0 : (nc == cur) ? run + 1 : 1;
      cur = nc;
    end
    tick;
    for (int i = 0; i < 16; i++) chk("rnd_mem", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
